// File: rtl/md_iteration_scheduler_pkg.sv
// Shared types for the MD iteration scheduler slice.
// Scheduler / tracker state encodings and a counter-width helper.
package md_iteration_scheduler_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_FORCE,
    SCH_MU,
    SCH_DONE
  } sched_state_t;

  typedef enum logic {
    WB_TRACK,
    WB_DRAIN
  } wb_track_state_t;

  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/md_iteration_scheduler_if.sv
// Control/status bundle between RL_top peers and the scheduler.
// master = environment side, slave = scheduler side. MD_ITER_PERF_EN adds perf counters.
interface md_iteration_scheduler_if #(
  parameter int NUM_CELLS  = 64,
  parameter int ITER_WIDTH = 16
`ifdef MD_ITER_PERF_EN
 ,parameter int PERF_WIDTH = 32
`endif
);

  logic                  start;
  logic [ITER_WIDTH-1:0] num_iters;
  logic [NUM_CELLS-1:0]  ref_wb_issued;
  logic                  goto_next_ref;
  logic                  all_reading_done;
  logic                  force_path_idle;
  logic                  mu_done;
  logic                  iter_start;
  logic                  all_ref_wb_issued;
  logic                  interconnect_empty;
  logic                  motion_update_start;
  logic [ITER_WIDTH-1:0] iter_count;
  logic                  busy;
  logic                  sim_done;
`ifdef MD_ITER_PERF_EN
  logic [PERF_WIDTH-1:0] force_cycles;
  logic [PERF_WIDTH-1:0] mu_cycles;
  logic [PERF_WIDTH-1:0] drain_cycles_total;
`endif

  modport master (
`ifdef MD_ITER_PERF_EN
    input  force_cycles, mu_cycles,
    input  drain_cycles_total,
`endif
    output start, num_iters,
    output ref_wb_issued, goto_next_ref,
    output all_reading_done,
    output force_path_idle, mu_done,
    input  iter_start, all_ref_wb_issued,
    input  interconnect_empty,
    input  motion_update_start,
    input  iter_count, busy, sim_done
  );

  modport slave (
`ifdef MD_ITER_PERF_EN
    output force_cycles, mu_cycles,
    output drain_cycles_total,
`endif
    input  start, num_iters,
    input  ref_wb_issued, goto_next_ref,
    input  all_reading_done,
    input  force_path_idle, mu_done,
    output iter_start, all_ref_wb_issued,
    output interconnect_empty,
    output motion_update_start,
    output iter_count, busy, sim_done
  );

endinterface

// File: rtl/md_iteration_scheduler_ref_wb_drain_tracker.sv
// Per-PE ref writeback sticky bits plus ring drain wait.
// Ports: clk/rst, en (FORCE), clr, wb, goto_next_ref -> all_ref_wb_issued, interconnect_empty.
module ref_wb_drain_tracker
  import md_iteration_scheduler_pkg::*;
#(
  parameter int NUM_CELLS    = 64,
  parameter int DRAIN_CYCLES = 64
`ifdef MD_ITER_PERF_EN
 ,parameter int PERF_WIDTH   = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [NUM_CELLS-1:0] wb,
  input  logic                 goto_next_ref,
`ifdef MD_ITER_PERF_EN
  input  logic                  perf_clr,
  output logic [PERF_WIDTH-1:0] drain_total,
`endif
  output logic                 all_ref_wb_issued,
  output logic                 interconnect_empty
);

  localparam int CW = cnt_width(DRAIN_CYCLES);
  localparam logic [CW-1:0] DMAX = CW'(DRAIN_CYCLES);

  wb_track_state_t      st;
  logic [NUM_CELLS-1:0] sticky;
  logic [NUM_CELLS-1:0] seen;
  logic [CW-1:0]        cnt;

  // a PE pulsing in the completing cycle counts immediately
  assign seen = sticky | wb;

  always_ff @(posedge clk) begin
    if (rst || !en || clr) begin
      st                <= WB_TRACK;
      sticky            <= '0;
      all_ref_wb_issued <= 1'b0;
      cnt               <= '0;
    end else begin
      unique case (st)
        WB_TRACK: begin
          sticky <= seen;
          if (&seen) begin
            all_ref_wb_issued <= 1'b1;
            cnt               <= '0;
            st                <= WB_DRAIN;
          end
        end
        WB_DRAIN: begin
          if (goto_next_ref) begin
            st                <= WB_TRACK;
            sticky            <= '0;
            all_ref_wb_issued <= 1'b0;
            cnt               <= '0;
          end else if (cnt != DMAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= WB_TRACK;
      endcase
    end
  end

  assign interconnect_empty = (st == WB_DRAIN) && (cnt == DMAX);

`ifdef MD_ITER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || perf_clr)
      drain_total <= '0;
    else if (st == WB_DRAIN && drain_total != '1)
      drain_total <= drain_total + 1'b1;
  end
`endif

endmodule

// File: rtl/md_iteration_scheduler.sv
// Force / motion-update iteration sequencer for RL_top.
// Ports: clk, rst, bus (slave). MD_ITER_PERF_EN adds FORCE/MU/DRAIN cycle counters.
module md_iteration_scheduler
  import md_iteration_scheduler_pkg::*;
#(
  parameter int NUM_CELLS    = 64,
  parameter int DRAIN_CYCLES = NUM_CELLS,
  parameter int ITER_WIDTH   = 16
`ifdef MD_ITER_PERF_EN
 ,parameter int PERF_WIDTH   = 32
`endif
) (
  input logic                     clk,
  input logic                     rst,
  md_iteration_scheduler_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = SCH_IDLE;
  localparam logic [1:0] ST_FORCE = SCH_FORCE;
  localparam logic [1:0] ST_MU    = SCH_MU;
  localparam logic [1:0] ST_DONE  = SCH_DONE;

  logic [1:0]            state;
  logic [ITER_WIDTH-1:0] limit;
  logic [ITER_WIDTH-1:0] cnt;
  logic [ITER_WIDTH-1:0] cnt_nx;
  logic                  iter_start_q;
  logic                  mus_q;
  logic                  all_wb;
  logic                  empty;
  logic                  in_force;
  logic                  go;
  logic                  fire;
  logic                  mu_hit;

  assign in_force = state == ST_FORCE;
  assign go       = (state == ST_IDLE || state == ST_DONE)
                    && bus.start;
  assign fire     = in_force && bus.all_reading_done
                    && bus.force_path_idle
                    && all_wb && empty;
  assign mu_hit   = (state == ST_MU) && bus.mu_done;
  assign cnt_nx   = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      limit        <= '0;
      cnt          <= '0;
      iter_start_q <= 1'b0;
      mus_q        <= 1'b0;
    end else begin
      iter_start_q <= 1'b0;
      mus_q        <= 1'b0;
      unique case (1'b1)
        go: begin
          cnt   <= '0;
          limit <= bus.num_iters;
          if (bus.num_iters == '0) begin
            state <= ST_DONE;
          end else begin
            state        <= ST_FORCE;
            iter_start_q <= 1'b1;
          end
        end
        fire: begin
          mus_q <= 1'b1;
          state <= ST_MU;
        end
        mu_hit: begin
          cnt <= cnt_nx;
          if (cnt_nx == limit) begin
            state <= ST_DONE;
          end else begin
            state        <= ST_FORCE;
            iter_start_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  ref_wb_drain_tracker #(
    .NUM_CELLS    (NUM_CELLS),
    .DRAIN_CYCLES (DRAIN_CYCLES)
`ifdef MD_ITER_PERF_EN
   ,.PERF_WIDTH   (PERF_WIDTH)
`endif
  ) u_trk (
    .clk                (clk),
    .rst                (rst),
    .en                 (in_force),
    .clr                (mus_q),
    .wb                 (bus.ref_wb_issued),
    .goto_next_ref      (bus.goto_next_ref),
`ifdef MD_ITER_PERF_EN
    .perf_clr           (go),
    .drain_total        (bus.drain_cycles_total),
`endif
    .all_ref_wb_issued  (all_wb),
    .interconnect_empty (empty)
  );

  assign bus.iter_start          = iter_start_q;
  assign bus.motion_update_start = mus_q;
  assign bus.all_ref_wb_issued   = all_wb;
  assign bus.interconnect_empty  = empty;
  assign bus.iter_count          = cnt;
  assign bus.busy     = (state == ST_FORCE) || (state == ST_MU);
  assign bus.sim_done = state == ST_DONE;

`ifdef MD_ITER_PERF_EN
  logic [PERF_WIDTH-1:0] fc;
  logic [PERF_WIDTH-1:0] mc;

  always_ff @(posedge clk) begin
    if (rst || go) begin
      fc <= '0;
      mc <= '0;
    end else begin
      if (in_force && fc != '1)
        fc <= fc + 1'b1;
      if (state == ST_MU && mc != '1)
        mc <= mc + 1'b1;
    end
  end

  assign bus.force_cycles = fc;
  assign bus.mu_cycles    = mc;
`endif

endmodule

// File: tb/tb_md_iteration_scheduler.sv
// Scoreboard bench for md_iteration_scheduler.
// Random writeback schedules; expected event cycles derived from timing rules.
module tb_md_iteration_scheduler;

  localparam int NC = 64;
  localparam int D  = NC;
  localparam int IW = 16;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  logic [NC-1:0] wbs [0:511];
  bit            gts [0:511];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  md_iteration_scheduler_if #(
    .NUM_CELLS  (NC),
    .ITER_WIDTH (IW)
  ) bus ();

  md_iteration_scheduler #(
    .NUM_CELLS    (NC),
    .DRAIN_CYCLES (D),
    .ITER_WIDTH   (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d",
               nm, got, exp);
    end
  endtask

  // kinds: 0 iter_start, 1 motion_update_start,
  //        2 all_ref_wb_issued rise, 3 interconnect_empty rise
  task automatic got_ev(input int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d",
               k, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.cyc != cyc ||
        e.cnt != int'(bus.iter_count)) begin
      errors++;
      $display("FAIL event got kind=%0d cyc=%0d cnt=%0d expected kind=%0d cyc=%0d cnt=%0d",
               k, cyc, bus.iter_count,
               e.kind, e.cyc, e.cnt);
    end
  endtask

  logic prev_all = 1'b0;
  logic prev_emp = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_all = 1'b0;
      prev_emp = 1'b0;
    end else begin
      if (bus.iter_start) got_ev(0);
      if (bus.motion_update_start) got_ev(1);
      if (bus.all_ref_wb_issued && !prev_all) got_ev(2);
      if (bus.interconnect_empty && !prev_emp) got_ev(3);
      prev_all = bus.all_ref_wb_issued;
      prev_emp = bus.interconnect_empty;
    end
  end

  task automatic idle_in();
    bus.start            = 1'b0;
    bus.num_iters        = '0;
    bus.ref_wb_issued    = '0;
    bus.goto_next_ref    = 1'b0;
    bus.all_reading_done = 1'b0;
    bus.force_path_idle  = 1'b1;
    bus.mu_done          = 1'b0;
  endtask

  task automatic push(input int k, input int c,
                      input int n);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.cnt  = n;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit abort);
    int s, l1, lf, g, tg, t1, w, r;
    int p0, p1, ct, m, k, tt, pe;
    int fexp, mexp;
    bit two;
    fexp = 0;
    mexp = 0;
    bus.start     = 1'b1;
    bus.num_iters = IW'(n);
    push(0, cyc + 1, 0);
    step();
    idle_in();
    for (int i = 0; i < n; i++) begin
      s = cyc;
      for (int t = 0; t < 512; t++) begin
        wbs[t] = '0;
        gts[t] = 1'b0;
      end
      w  = $urandom_range(0, 40);
      l1 = 0;
      for (int p = 0; p < NC; p++) begin
        tt = $urandom_range(0, w);
        wbs[tt][p] = 1'b1;
        if (tt > l1) l1 = tt;
      end
      for (int j = 0; j < 4; j++) begin
        tt = $urandom_range(0, l1);
        pe = $urandom_range(0, NC - 1);
        wbs[tt][pe] = 1'b1;
      end
      tt = $urandom_range(0, l1);
      gts[tt] = 1'b1;
      two = $urandom_range(0, 1) == 1;
      lf  = l1;
      if (two) begin
        g  = $urandom_range(0, D - 1);
        tg = l1 + 1 + g;
        gts[tg] = 1'b1;
        t1 = tg + 1;
        w  = $urandom_range(0, 40);
        lf = t1;
        for (int p = 0; p < NC; p++) begin
          tt = t1 + $urandom_range(0, w);
          wbs[tt][p] = 1'b1;
          if (tt > lf) lf = tt;
        end
      end
      r  = $urandom_range(0, lf + D + 30);
      p0 = $urandom_range(0, lf + D + 20);
      p1 = p0 + $urandom_range(0, 15);
      ct = (lf + 1 + D > r) ? lf + 1 + D : r;
      while (ct >= p0 && ct < p1) ct++;
      m = ct + 1;
      k = abort ? 5 : $urandom_range(0, 5);
      fexp += m;
      mexp += k + 1;
      push(2, s + l1 + 1, i);
      if (two) push(2, s + lf + 1, i);
      push(3, s + lf + 1 + D, i);
      push(1, s + m, i);
      if (i < n - 1 && !abort) push(0, s + m + k + 1, i + 1);
      for (int t = 0; t <= m + k; t++) begin
        bus.ref_wb_issued    = wbs[t];
        bus.goto_next_ref    = gts[t];
        bus.all_reading_done = t >= r;
        bus.force_path_idle  = !(t >= p0 && t < p1);
        bus.mu_done          = (t == 0) || (t == m + k);
        bus.start            = t == 1;
        bus.num_iters        = '0;
        if (abort && t == m + 1) rst = 1'b1;
        step();
        if (abort && t == m + 1) break;
      end
      idle_in();
      if (abort) begin
        chk("abort_iter_start", bus.iter_start, 0);
        chk("abort_mu_start", bus.motion_update_start, 0);
        chk("abort_all_wb", bus.all_ref_wb_issued, 0);
        chk("abort_empty", bus.interconnect_empty, 0);
        chk("abort_count", bus.iter_count, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.sim_done, 0);
        rst = 1'b0;
        step();
        return;
      end
    end
    chk("run_sim_done", bus.sim_done, 1);
    chk("run_busy", bus.busy, 0);
    chk("run_count", bus.iter_count, n);
`ifdef MD_ITER_PERF_EN
    chk("perf_force", bus.force_cycles, fexp);
    chk("perf_mu", bus.mu_cycles, mexp);
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    repeat (3) step();
    chk("rst_iter_start", bus.iter_start, 0);
    chk("rst_mu_start", bus.motion_update_start, 0);
    chk("rst_all_wb", bus.all_ref_wb_issued, 0);
    chk("rst_empty", bus.interconnect_empty, 0);
    chk("rst_count", bus.iter_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.sim_done, 0);
    rst = 1'b0;
    step();
    run(2, 1'b0);
    run(3, 1'b0);
    bus.start     = 1'b1;
    bus.num_iters = '0;
    step();
    idle_in();
    chk("zero_sim_done", bus.sim_done, 1);
    chk("zero_count", bus.iter_count, 0);
    chk("zero_busy", bus.busy, 0);
    step();
    run(2, 1'b1);
    for (int j = 0; j < 3; j++)
      run($urandom_range(1, 3), 1'b0);
    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
